pencere_sirali_kontrol: RTL and testbench
=========================================

Name: pencere_sirali_kontrol

Overview:
- Frame-level sequencer that drives a single 3x3 neighbourhood kernel unit, such as the erosion unit, over a raster image held in a single-port frame RAM.
- Per output pixel:
  - reads the 9 neighbour pixels; out-of-frame neighbours take the pad value;
  - hands the packed window to the kernel over a valid/ready handshake;
  - waits for the kernel result;
  - writes the result to the output RAM at the pixel's linear address.
- Sits between the frame buffers and the kernel unit, replacing ad-hoc padded-copy buffers.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- PIX_W, 8, pixel width
- PAD_VAL, 0, value used for out-of-frame neighbours

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start one frame pass; sampled only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until DONE
- done_o  out  1  one-cycle pulse at frame completion
- rd_en_o  out  1  frame RAM read enable
- rd_addr_o  out  ADDR_W  frame RAM read address (y*IMG_W+x)
- rd_data_i  in  PIX_W  frame RAM data, valid exactly 1 cycle after rd_en_o
- pencere_o  out  9*PIX_W  window; tap k at bits [k*PIX_W +: PIX_W]; k=0 is top-left, row-major
- pencere_valid_o  out  1  window valid to kernel
- pencere_ready_i  in  1  kernel accepts window
- sonuc_valid_i  in  1  kernel result valid
- sonuc_i  in  PIX_W  kernel result
- wr_en_o  out  1  output RAM write enable
- wr_addr_o  out  ADDR_W  output RAM address
- wr_data_o  out  PIX_W  output RAM data

Behaviour:
- Reset: state IDLE; x=y=0; tap counter 0. All outputs 0, including pencere_o.
- Reset mid-frame aborts the pass immediately. No done_o pulse. No further RAM accesses.
- IDLE: if start_i=1, clear x, y and k, then go to FETCH. start_i while busy is ignored.
- FETCH: lasts exactly 10 cycles, c=0..9.
  - Cycle c<9 handles tap k=c:
    - dx = c%3 - 1, dy = c/3 - 1; nx = x+dx, ny = y+dy.
    - If 0<=nx<IMG_W and 0<=ny<IMG_H: rd_en_o=1, rd_addr_o = ny*IMG_W + nx.
    - Otherwise rd_en_o=0 and tap k is marked pad.
  - Cycle c>=1 captures tap c-1: rd_data_i, or PAD_VAL if marked pad.
  - Then go to ISSUE.
- ISSUE:
  - pencere_valid_o=1 with pencere_o held stable until the cycle in which pencere_ready_i=1.
  - In that cycle the window transfers; next state is WAIT and valid drops.
- WAIT: on the first cycle with sonuc_valid_i=1, latch sonuc_i and go to WRITE.
  - sonuc_valid_i in any other state is ignored.
  - sonuc_valid_i in the same cycle as the ISSUE handshake is not counted.
  - No timeout.
- WRITE: one cycle.
  - wr_en_o=1, wr_addr_o = y*IMG_W + x, wr_data_o = latched result.
  - Then go to NEXT.
- NEXT: one cycle.
  - If x=IMG_W-1 and y=IMG_H-1: go to DONE.
  - Else if x=IMG_W-1: x=0, y=y+1.
  - Else x=x+1.
  - Then go to FETCH.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- Addressing:
  - Linear addresses are computed with a running row base: add IMG_W per row, with row +/-1 offsets of IMG_W. No multiplier.
  - Arithmetic is ADDR_W bits, with no wrap inside the frame.
- Minimum pixel period, with ready and result in the same cycles they are first eligible: 10+1+1+1+1 = 14 cycles.
- Frame RAM read count per pixel:
  - 4 at corners;
  - 6 on non-corner edges;
  - 9 for interior pixels.

Decomposition:
- Shared package pencere_pkg holds:
  - state encoding constants IDLE, FETCH, ISSUE, WAIT, WRITE, NEXT, DONE;
  - tap count 9;
  - tap offset tables (dx, dy per k).
- One natural sub-module, pencere_adres_uret: a combinational/registered address and in-bounds generator from (x, y, k, row base).
- The FSM and window registers stay in the top level.

Test Plan:
- IMG_W=4, IMG_H=3, RAM holds addr value:
  - pixel (0,0) reads only addrs 0,1,4,5;
  - taps 0,1,2,3,6 = 0;
  - taps 4,5,7,8 = 0,1,4,5.
- Interior pixel (1,1) on the same image: 9 reads, addrs 0,1,2,4,5,6,8,9,10, in tap order; pencere_o equals those values.
- Kernel model with ready always 1 and result = tap4 + 1 one cycle later:
  - 12 writes, addr 0..11, data addr+1;
  - one done_o pulse exactly 14*12+1 cycles after start;
  - busy_o low afterwards.
- pencere_ready_i held low 5 cycles: pencere_o/valid stay constant; transfer happens on the ready cycle; no duplicate write.
- Spurious sonuc_valid_i during FETCH and ISSUE: ignored; wr_en_o count is still exactly 12.
- rst_i asserted mid-frame at pixel 5: next cycle all outputs 0. Then start_i: the pass restarts at addr 0 and completes normally.

Source files
------------

// File: rtl/pencere_sirali_kontrol_pkg.sv
// rtl/pencere_sirali_kontrol_pkg.sv - shared states and 3x3 tap offset tables
package pencere_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        WRITE,
        NEXT,
        DONE
    } durum_t;

    localparam int TAP_SAYISI = 9;

    // Row-major 3x3 offsets; tap 4 is the centre pixel.
    localparam logic signed [1:0] TAP_DX [TAP_SAYISI] = '{
        -2'sd1, 2'sd0, 2'sd1,
        -2'sd1, 2'sd0, 2'sd1,
        -2'sd1, 2'sd0, 2'sd1
    };
    localparam logic signed [1:0] TAP_DY [TAP_SAYISI] = '{
        -2'sd1, -2'sd1, -2'sd1,
         2'sd0,  2'sd0,  2'sd0,
         2'sd1,  2'sd1,  2'sd1
    };

endpackage

// File: rtl/pencere_sirali_kontrol_if.sv
// rtl/pencere_sirali_kontrol_if.sv - frame RAM, output RAM and kernel handshake bundle
interface pencere_sirali_kontrol_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
);
    logic                 rd_en_o;
    logic [ADDR_W-1:0]    rd_addr_o;
    logic [PIX_W-1:0]     rd_data_i;
    logic [9*PIX_W-1:0]   pencere_o;
    logic                 pencere_valid_o;
    logic                 pencere_ready_i;
    logic                 sonuc_valid_i;
    logic [PIX_W-1:0]     sonuc_i;
    logic                 wr_en_o;
    logic [ADDR_W-1:0]    wr_addr_o;
    logic [PIX_W-1:0]     wr_data_o;

    modport master (
        output rd_en_o, rd_addr_o, pencere_o, pencere_valid_o,
               wr_en_o, wr_addr_o, wr_data_o,
        input  rd_data_i, pencere_ready_i, sonuc_valid_i, sonuc_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, pencere_o, pencere_valid_o,
               wr_en_o, wr_addr_o, wr_data_o,
        output rd_data_i, pencere_ready_i, sonuc_valid_i, sonuc_i
    );
endinterface

// File: rtl/pencere_sirali_kontrol_adres_uret.sv
// rtl/pencere_sirali_kontrol_adres_uret.sv - neighbour address and in-frame test for one tap
module pencere_adres_uret
    import pencere_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic [ADDR_W-1:0] x_i,
    input  logic [ADDR_W-1:0] y_i,
    input  logic [ADDR_W-1:0] satir_taban_i,
    input  logic [3:0]        k_i,
    output logic [ADDR_W-1:0] adr_o,
    output logic              ici_o
);
    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] SON_X = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] SON_Y = ADDR_W'(IMG_H - 1);

    logic signed [1:0]  dx;
    logic signed [1:0]  dy;
    logic [ADDR_W-1:0]  satir;
    logic [ADDR_W-1:0]  adr;
    logic               ici;

    // Out-of-frame taps may underflow/overflow here; they are masked by ici.
    always_comb begin
        dx    = TAP_DX[k_i];
        dy    = TAP_DY[k_i];
        ici   = 1'b1;
        satir = satir_taban_i;
        if (dy == -2'sd1) begin
            ici   = ici & (y_i != '0);
            satir = satir_taban_i - W_A;
        end else if (dy == 2'sd1) begin
            ici   = ici & (y_i != SON_Y);
            satir = satir_taban_i + W_A;
        end
        adr = satir + x_i;
        if (dx == -2'sd1) begin
            ici = ici & (x_i != '0);
            adr = satir + x_i - ADDR_W'(1);
        end else if (dx == 2'sd1) begin
            ici = ici & (x_i != SON_X);
            adr = satir + x_i + ADDR_W'(1);
        end
        adr_o = ici ? adr : '0;
        ici_o = ici;
    end
endmodule

// File: rtl/pencere_sirali_kontrol.sv
// rtl/pencere_sirali_kontrol.sv - raster sequencer feeding padded 3x3 windows to a kernel unit
module pencere_sirali_kontrol
    import pencere_pkg::*;
#(
    parameter int              IMG_W   = 320,
    parameter int              IMG_H   = 240,
    parameter int              ADDR_W  = 17,
    parameter int              PIX_W   = 8,
    parameter logic [PIX_W-1:0] PAD_VAL = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    pencere_sirali_kontrol_if.master bus
);
    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] SON_X = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] SON_Y = ADDR_W'(IMG_H - 1);

    durum_t                        durum;
    logic [ADDR_W-1:0]             x;
    logic [ADDR_W-1:0]             y;
    logic [ADDR_W-1:0]             satir_taban;
    logic [3:0]                    c;
    logic [3:0]                    k;
    logic [3:0]                    c_onceki;
    logic [TAP_SAYISI-1:0]         pad;
    logic [TAP_SAYISI*PIX_W-1:0]   pencere;
    logic                          pencere_valid;
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [PIX_W-1:0]              wr_data;
    logic [ADDR_W-1:0]             adr;
    logic                          ici;
    logic                          rd_en;

    assign k        = (c < 4'd9) ? c : 4'd0;
    assign c_onceki = c - 4'd1;

    pencere_adres_uret #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_adres (
        .x_i           (x),
        .y_i           (y),
        .satir_taban_i (satir_taban),
        .k_i           (k),
        .adr_o         (adr),
        .ici_o         (ici)
    );

    assign rd_en               = (durum == FETCH) && (c < 4'd9) && ici;
    assign bus.rd_en_o         = rd_en;
    assign bus.rd_addr_o       = rd_en ? adr : '0;
    assign bus.pencere_o       = pencere;
    assign bus.pencere_valid_o = pencere_valid;
    assign bus.wr_en_o         = wr_en;
    assign bus.wr_addr_o       = wr_addr;
    assign bus.wr_data_o       = wr_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum         <= IDLE;
            x             <= '0;
            y             <= '0;
            satir_taban   <= '0;
            c             <= '0;
            pad           <= '0;
            pencere       <= '0;
            pencere_valid <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            case (durum)
                IDLE: begin
                    if (start_i) begin
                        x           <= '0;
                        y           <= '0;
                        satir_taban <= '0;
                        c           <= '0;
                        busy_o      <= 1'b1;
                        durum       <= FETCH;
                    end
                end
                FETCH: begin
                    // Issue tap c while capturing tap c-1 from last cycle's read.
                    if (c < 4'd9) begin
                        pad[c] <= !ici;
                    end
                    if (c != 4'd0) begin
                        pencere[c_onceki*PIX_W +: PIX_W] <= pad[c_onceki] ? PAD_VAL : bus.rd_data_i;
                    end
                    if (c == 4'd9) begin
                        c             <= '0;
                        pencere_valid <= 1'b1;
                        durum         <= ISSUE;
                    end else begin
                        c <= c + 4'd1;
                    end
                end
                ISSUE: begin
                    if (bus.pencere_ready_i) begin
                        pencere_valid <= 1'b0;
                        durum         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.sonuc_valid_i) begin
                        wr_en   <= 1'b1;
                        wr_addr <= satir_taban + x;
                        wr_data <= bus.sonuc_i;
                        durum   <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    durum <= NEXT;
                end
                NEXT: begin
                    if (x == SON_X && y == SON_Y) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        durum  <= DONE;
                    end else begin
                        if (x == SON_X) begin
                            x           <= '0;
                            y           <= y + ADDR_W'(1);
                            satir_taban <= satir_taban + W_A;
                        end else begin
                            x <= x + ADDR_W'(1);
                        end
                        durum <= FETCH;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    durum  <= IDLE;
                end
                default: durum <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pencere_sirali_kontrol.sv
// tb/tb_pencere_sirali_kontrol.sv - directed bench on a 4x3 frame whose RAM holds its own address
module tb_pencere_sirali_kontrol;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 17;
    localparam int PW   = 8;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    pencere_sirali_kontrol_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

    pencere_sirali_kontrol #(
        .IMG_W   (W),
        .IMG_H   (H),
        .ADDR_W  (AW),
        .PIX_W   (PW),
        .PAD_VAL (8'h00)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          rd_adr_q[$];
    int          rd_pix_q[$];
    int          wr_adr_q[$];
    int          wr_dat_q[$];
    logic [71:0] win_q[$];
    int          wr_cnt    = 0;
    int          valid_cnt = 0;
    int          done_cnt  = 0;
    int          hold_left = 0;
    int          hold_bad  = 0;
    bit          hold_seen = 0;
    bit          spur      = 0;
    bit          pend      = 0;
    logic [7:0]  pend_val  = 8'h00;
    logic [7:0]  rd_pend   = 8'hA5;
    logic [71:0] held      = '0;

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
        n_chk++;
        if (gozlenen !== beklenen) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    function automatic logic [71:0] bek_pencere(input int p);
        logic [71:0] w;
        int px;
        int py;
        int nx;
        int ny;
        w  = '0;
        px = p % W;
        py = p / W;
        for (int k = 0; k < 9; k++) begin
            nx = px + k % 3 - 1;
            ny = py + k / 3 - 1;
            if (nx >= 0 && nx < W && ny >= 0 && ny < H) w[k*8 +: 8] = 8'(ny * W + nx);
        end
        return w;
    endfunction

    function automatic int bek_okuma(input int p);
        int n;
        int nx;
        int ny;
        n = 0;
        for (int k = 0; k < 9; k++) begin
            nx = p % W + k % 3 - 1;
            ny = p / W + k / 3 - 1;
            if (nx >= 0 && nx < W && ny >= 0 && ny < H) n++;
        end
        return n;
    endfunction

    // Frame RAM (data = address, one-cycle latency) and kernel (result = centre tap + 1).
    always @(negedge clk) begin
        bus.rd_data_i = rd_pend;
        rd_pend = bus.rd_en_o ? bus.rd_addr_o[7:0] : 8'hA5;
        if (bus.rd_en_o) begin
            rd_adr_q.push_back(int'(bus.rd_addr_o));
            rd_pix_q.push_back(wr_cnt);
        end
        bus.sonuc_valid_i   = pend | spur;
        bus.sonuc_i         = pend ? pend_val : 8'hEE;
        bus.pencere_ready_i = 1'b1;
        if (bus.pencere_valid_o) begin
            valid_cnt++;
            if (hold_seen && bus.pencere_o != held) hold_bad++;
            if (hold_left > 0) begin
                bus.pencere_ready_i = 1'b0;
                if (!hold_seen) begin
                    held      = bus.pencere_o;
                    hold_seen = 1;
                end
                hold_left--;
            end else begin
                hold_seen = 0;
            end
        end
        pend     = bus.pencere_valid_o && bus.pencere_ready_i && !rst;
        pend_val = bus.pencere_o[4*PW +: PW] + 8'd1;
        if (pend) win_q.push_back(bus.pencere_o);
        if (bus.wr_en_o) begin
            wr_adr_q.push_back(int'(bus.wr_addr_o));
            wr_dat_q.push_back(int'(bus.wr_data_o));
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic temizle();
        rd_adr_q.delete();
        rd_pix_q.delete();
        wr_adr_q.delete();
        wr_dat_q.delete();
        win_q.delete();
        wr_cnt    = 0;
        valid_cnt = 0;
        done_cnt  = 0;
        hold_bad  = 0;
    endtask

    task automatic baslat();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cerceve_kos(input string tag, output int n);
        temizle();
        baslat();
        n = 1;
        kontrol({tag, "_busy_after_start"}, busy, 1'b1);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        kontrol({tag, "_done_seen"}, done, 1'b1);
        @(negedge clk);
        kontrol({tag, "_done_pulse_count"}, done_cnt, 1);
        kontrol({tag, "_busy_after_done"}, busy, 1'b0);
        kontrol({tag, "_done_low_after"}, done, 1'b0);
    endtask

    task automatic yazma_kontrol(input string tag);
        kontrol({tag, "_wr_count"}, wr_adr_q.size(), NPIX);
        for (int p = 0; p < NPIX && p < wr_adr_q.size(); p++) begin
            kontrol({tag, "_wr_addr"}, wr_adr_q[p], p);
            kontrol({tag, "_wr_data"}, wr_dat_q[p], p + 1);
        end
    endtask

    task automatic okuma_dizisi(input int p, input int beklenen[$]);
        int got[$];
        for (int i = 0; i < rd_adr_q.size(); i++)
            if (rd_pix_q[i] == p) got.push_back(rd_adr_q[i]);
        kontrol($sformatf("px%0d_read_count", p), got.size(), beklenen.size());
        for (int i = 0; i < got.size() && i < beklenen.size(); i++)
            kontrol($sformatf("px%0d_read_addr%0d", p, i), got[i], beklenen[i]);
    endtask

    int n;
    int okuma_sayisi;
    int onceki_rd;
    int onceki_wr;
    int t;
    int bek0[$];
    int bek5[$];

    initial begin
        bek0 = '{0, 1, 4, 5};
        bek5 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

        repeat (3) @(negedge clk);
        kontrol("rst_busy", busy, 1'b0);
        kontrol("rst_done", done, 1'b0);
        kontrol("rst_rd_en", bus.rd_en_o, 1'b0);
        kontrol("rst_rd_addr", bus.rd_addr_o, 0);
        kontrol("rst_valid", bus.pencere_valid_o, 1'b0);
        kontrol("rst_pencere", bus.pencere_o, 0);
        kontrol("rst_wr_en", bus.wr_en_o, 1'b0);
        kontrol("rst_wr_addr", bus.wr_addr_o, 0);
        kontrol("rst_wr_data", bus.wr_data_o, 0);
        rst = 1'b0;

        // Full frame, ready always high.
        cerceve_kos("norm", n);
        kontrol("norm_done_cycle", n, 14 * NPIX + 1);
        yazma_kontrol("norm");
        kontrol("norm_window_count", win_q.size(), NPIX);
        for (int p = 0; p < NPIX && p < win_q.size(); p++)
            kontrol($sformatf("norm_window_px%0d", p), win_q[p], bek_pencere(p));
        okuma_dizisi(0, bek0);
        okuma_dizisi(5, bek5);
        for (int p = 0; p < NPIX; p++) begin
            okuma_sayisi = 0;
            foreach (rd_pix_q[i]) if (rd_pix_q[i] == p) okuma_sayisi++;
            kontrol($sformatf("px%0d_reads", p), okuma_sayisi, bek_okuma(p));
        end

        // Ready held low for 5 cycles on the first window.
        hold_left = 5;
        cerceve_kos("hold", n);
        kontrol("hold_done_cycle", n, 14 * NPIX + 1 + 5);
        kontrol("hold_valid_cycles", valid_cnt, NPIX + 5);
        kontrol("hold_window_stable", hold_bad, 0);
        yazma_kontrol("hold");

        // Result valid asserted outside WAIT must not be taken.
        spur = 1;
        cerceve_kos("spur", n);
        spur = 0;
        kontrol("spur_done_cycle", n, 14 * NPIX + 1);
        yazma_kontrol("spur");

        // Reset while pixel 5 is being fetched, then a clean restart.
        temizle();
        baslat();
        t = 0;
        while (wr_cnt < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        kontrol("abort_reached_px5", wr_cnt, 5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        kontrol("abort_outputs", {busy, done, bus.rd_en_o, bus.pencere_valid_o, bus.wr_en_o}, 0);
        kontrol("abort_pencere", bus.pencere_o, 0);
        kontrol("abort_addrs", {bus.rd_addr_o, bus.wr_addr_o, bus.wr_data_o}, 0);
        onceki_rd = rd_adr_q.size();
        onceki_wr = wr_cnt;
        repeat (5) @(negedge clk);
        kontrol("abort_no_reads", rd_adr_q.size(), onceki_rd);
        kontrol("abort_no_writes", wr_cnt, onceki_wr);
        kontrol("abort_no_done", done_cnt, 0);
        cerceve_kos("restart", n);
        kontrol("restart_done_cycle", n, 14 * NPIX + 1);
        kontrol("restart_first_read", rd_adr_q.size() > 0 ? rd_adr_q[0] : -1, 0);
        yazma_kontrol("restart");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
